argon_alu_sequencer: RTL and testbench

Upstream command sequencer for the Argon ALU: it accepts one ALU operation (opcode, two operands, carry-in) over a valid/ready request port. It then drives the ALU's shared bus and latch/output strobes through a fixed multi-cycle sequence, and returns the 16-bit result plus the flags word on a valid/ready response port. It sits between the core control unit and the ALU and is the only bus master of the ALU's input bus.

---
 rtl/argon_pkg.sv | 58 +++++
 rtl/argon_alu_sequencer.sv | 160 ++++++++++++++++
 tb/tb_argon_alu_sequencer.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/argon_pkg.sv
// argon_pkg: shared definitions for the Argon ALU and its upstream sequencer.
//   WORDSIZE / word_t   : datapath width (16 bits)
//   ALU_*               : ALU opcode encoding (4 bits; 13..15 are reserved)
//   F_*                 : bit indices inside the ALU flags word
//   alu_seq_state_t     : sequencer FSM states
//   ALU_SEQ_LATENCY     : cycles from accept cycle to response-valid cycle
//   alu_op_valid()      : true for the opcodes the ALU implements
package argon_pkg;

  localparam int WORDSIZE = 16;
  typedef logic [WORDSIZE-1:0] word_t;

  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_ADC  = 4'h1;
  localparam logic [3:0] ALU_SBC  = 4'h2;
  localparam logic [3:0] ALU_INC  = 4'h3;
  localparam logic [3:0] ALU_DEC  = 4'h4;
  localparam logic [3:0] ALU_NAND = 4'h5;
  localparam logic [3:0] ALU_AND  = 4'h6;
  localparam logic [3:0] ALU_OR   = 4'h7;
  localparam logic [3:0] ALU_NOR  = 4'h8;
  localparam logic [3:0] ALU_XOR  = 4'h9;
  localparam logic [3:0] ALU_LSH  = 4'hA;
  localparam logic [3:0] ALU_RSH  = 4'hB;
  localparam logic [3:0] ALU_CMP  = 4'hC;

  localparam int F_CARRY   = 0;
  localparam int F_ZERO    = 1;
  localparam int F_LESS    = 2;
  localparam int F_EQUAL   = 3;
  localparam int F_GREATER = 4;

  localparam int ALU_SEQ_LATENCY = 10;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    LD_OP = 4'd1,
    LD_A  = 4'd2,
    LD_B  = 4'd3,
    LD_F  = 4'd4,
    EXEC  = 4'd5,
    RD_Y  = 4'd6,
    RST_F = 4'd7,
    EXEC2 = 4'd8,
    RD_F  = 4'd9,
    DONE  = 4'd10
  } alu_seq_state_t;

  function automatic logic alu_op_valid(input logic [3:0] op);
    case (op)
      ALU_ADD, ALU_ADC, ALU_SBC, ALU_INC, ALU_DEC,
      ALU_NAND, ALU_AND, ALU_OR, ALU_NOR, ALU_XOR,
      ALU_LSH, ALU_RSH, ALU_CMP: alu_op_valid = 1'b1;
      default:                   alu_op_valid = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/argon_alu_sequencer.sv
// argon_alu_sequencer: accepts one ALU operation on a valid/ready request
// port, walks the ALU through load / execute / read cycles on its shared
// bus, and returns the result and flags word on a valid/ready response port.
//   i_Clk, i_Reset             : clock, asynchronous active-high reset
//   i_req_valid / o_req_ready  : request handshake (ready only in IDLE)
//   i_req_op, i_req_a/b, i_req_carry : operation, operands, carry-in
//   o_alu_bus                  : value driven onto the ALU input bus
//   o_alu_latch{A,B,F,Op}      : ALU latch strobes
//   o_alu_output{Y,F}          : ALU read strobes
//   i_alu_bus                  : ALU output bus
//   o_rsp_valid / i_rsp_ready  : response handshake
//   o_rsp_y, o_rsp_flags, o_rsp_err : result, flags, reserved-op error
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The request side is ready only in IDLE; the response side holds
// valid and all o_rsp_* stable in DONE until i_rsp_ready is seen high.
import argon_pkg::*;

module argon_alu_sequencer (
  input  logic        i_Clk,
  input  logic        i_Reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [3:0]  i_req_op,
  input  word_t       i_req_a,
  input  word_t       i_req_b,
  input  logic        i_req_carry,
  output word_t       o_alu_bus,
  output logic        o_alu_latchA,
  output logic        o_alu_latchB,
  output logic        o_alu_latchF,
  output logic        o_alu_latchOp,
  output logic        o_alu_outputY,
  output logic        o_alu_outputF,
  input  word_t       i_alu_bus,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output word_t       o_rsp_y,
  output word_t       o_rsp_flags,
  output logic        o_rsp_err
);

  alu_seq_state_t state_q, state_d;

  logic [3:0] op_q;
  word_t      a_q;
  word_t      b_q;
  logic       carry_q;
  word_t      y_q;
  word_t      rsp_y_q;
  word_t      rsp_flags_q;
  logic       rsp_err_q;
  word_t      carry_word;

  // Flags word that seeds the ALU: only the carry bit is meaningful.
  always_comb begin
    carry_word          = '0;
    carry_word[F_CARRY] = carry_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_req_valid) state_d = alu_op_valid(i_req_op) ? LD_OP : DONE;
      LD_OP:   state_d = LD_A;
      LD_A:    state_d = LD_B;
      LD_B:    state_d = LD_F;
      LD_F:    state_d = EXEC;
      EXEC:    state_d = RD_Y;
      RD_Y:    state_d = RST_F;
      RST_F:   state_d = EXEC2;
      EXEC2:   state_d = RD_F;
      RD_F:    state_d = DONE;
      DONE:    if (i_rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus and strobes decode straight from the registered state, so reset
  // forces them all low immediately. The bus is only non-zero alongside a
  // latch strobe.
  always_comb begin
    o_alu_bus     = '0;
    o_alu_latchA  = 1'b0;
    o_alu_latchB  = 1'b0;
    o_alu_latchF  = 1'b0;
    o_alu_latchOp = 1'b0;
    o_alu_outputY = 1'b0;
    o_alu_outputF = 1'b0;
    case (state_q)
      LD_OP: begin
        o_alu_bus     = {{(WORDSIZE-4){1'b0}}, op_q};
        o_alu_latchOp = 1'b1;
      end
      LD_A: begin
        o_alu_bus    = a_q;
        o_alu_latchA = 1'b1;
      end
      LD_B: begin
        o_alu_bus    = b_q;
        o_alu_latchB = 1'b1;
      end
      // RST_F reloads the carry-in: the ALU re-executes during RD_Y, which
      // corrupts the carry for ADC/SBC before the flags are read.
      LD_F, RST_F: begin
        o_alu_bus    = carry_word;
        o_alu_latchF = 1'b1;
      end
      RD_Y:    o_alu_outputY = 1'b1;
      RD_F:    o_alu_outputF = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_q     <= IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      y_q         <= '0;
      rsp_y_q     <= '0;
      rsp_flags_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (i_req_valid) begin
            op_q    <= i_req_op;
            a_q     <= i_req_a;
            b_q     <= i_req_b;
            carry_q <= i_req_carry;
            // Reserved op: response is loaded on the same edge that enters DONE.
            if (!alu_op_valid(i_req_op)) begin
              rsp_y_q     <= '0;
              rsp_flags_q <= '0;
              rsp_err_q   <= 1'b1;
            end
          end
        end
        RD_Y: y_q <= i_alu_bus;
        RD_F: begin
          rsp_y_q     <= (op_q == ALU_CMP) ? '0 : y_q;
          rsp_flags_q <= i_alu_bus;
          rsp_err_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign o_req_ready = (state_q == IDLE);
  assign o_rsp_valid = (state_q == DONE);
  assign o_rsp_y     = rsp_y_q;
  assign o_rsp_flags = rsp_flags_q;
  assign o_rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_argon_alu_sequencer.sv
// tb_argon_alu_sequencer: drives argon_alu_sequencer against a behavioural
// model of the Argon ALU and compares each response with a reference
// computed directly from the operation's arithmetic.
import argon_pkg::*;

module tb_argon_alu_sequencer;

  // ---------------- clock / reset ----------------
  logic i_Clk = 1'b0;
  logic i_Reset = 1'b1;
  always #5 i_Clk = ~i_Clk;

  logic       i_req_valid = 1'b0;
  logic       o_req_ready;
  logic [3:0] i_req_op = '0;
  word_t      i_req_a = '0;
  word_t      i_req_b = '0;
  logic       i_req_carry = 1'b0;
  word_t      o_alu_bus;
  logic       o_alu_latchA, o_alu_latchB, o_alu_latchF, o_alu_latchOp;
  logic       o_alu_outputY, o_alu_outputF;
  word_t      i_alu_bus;
  logic       o_rsp_valid;
  logic       i_rsp_ready = 1'b0;
  word_t      o_rsp_y;
  word_t      o_rsp_flags;
  logic       o_rsp_err;

  argon_alu_sequencer dut (
    .i_Clk(i_Clk), .i_Reset(i_Reset),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_op(i_req_op), .i_req_a(i_req_a), .i_req_b(i_req_b),
    .i_req_carry(i_req_carry),
    .o_alu_bus(o_alu_bus),
    .o_alu_latchA(o_alu_latchA), .o_alu_latchB(o_alu_latchB),
    .o_alu_latchF(o_alu_latchF), .o_alu_latchOp(o_alu_latchOp),
    .o_alu_outputY(o_alu_outputY), .o_alu_outputF(o_alu_outputF),
    .i_alu_bus(i_alu_bus),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_y(o_rsp_y), .o_rsp_flags(o_rsp_flags), .o_rsp_err(o_rsp_err)
  );

  // ---------------- ALU arithmetic (returns {flags, y}) ----------------
  function automatic logic [31:0] alu_fn(input logic [3:0] op, input word_t a,
                                         input word_t b, input word_t f);
    logic [16:0] w;
    word_t       fl;
    logic        c;
    c  = f[F_CARRY];
    fl = '0;
    w  = '0;
    case (op)
      ALU_ADD:  w = {1'b0, a} + {1'b0, b};
      ALU_ADC:  w = {1'b0, a} + {1'b0, b} + {16'b0, c};
      ALU_SBC:  w = {1'b0, a} - {1'b0, b} - {16'b0, c};
      ALU_INC:  w = {1'b0, a} + 17'd1;
      ALU_DEC:  w = {1'b0, a} - 17'd1;
      ALU_NAND: w = {1'b0, ~(a & b)};
      ALU_AND:  w = {1'b0, a & b};
      ALU_OR:   w = {1'b0, a | b};
      ALU_NOR:  w = {1'b0, ~(a | b)};
      ALU_XOR:  w = {1'b0, a ^ b};
      ALU_LSH:  w = {a, 1'b0};
      ALU_RSH:  w = {a[0], 1'b0, a[15:1]};
      ALU_CMP: begin
        w = {1'b0, a - b};
        fl[F_LESS]    = (a < b);
        fl[F_EQUAL]   = (a == b);
        fl[F_GREATER] = (a > b);
      end
      default:  w = '0;
    endcase
    fl[F_CARRY] = w[16];
    fl[F_ZERO]  = (w[15:0] == 16'h0);
    return {fl, w[15:0]};
  endfunction

  // ---------------- ALU model wired to the sequencer ----------------
  word_t      alu_a = '0, alu_b = '0, alu_f = '0, alu_y = '0;
  logic [3:0] alu_op = '0;
  always @(posedge i_Clk) begin
    if (o_alu_latchOp) alu_op <= o_alu_bus[3:0];
    if (o_alu_latchA)  alu_a  <= o_alu_bus;
    if (o_alu_latchB)  alu_b  <= o_alu_bus;
    if (o_alu_latchF)  alu_f  <= o_alu_bus;
    if (!(o_alu_latchOp || o_alu_latchA || o_alu_latchB || o_alu_latchF))
      {alu_f, alu_y} <= alu_fn(alu_op, alu_a, alu_b, alu_f);
  end
  assign i_alu_bus = o_alu_outputY ? alu_y : (o_alu_outputF ? alu_f : '0);

  // ---------------- reference: {err, flags, y} per request ----------------
  function automatic logic [32:0] ref_rsp(input logic [3:0] op, input word_t a,
                                          input word_t b, input logic c);
    logic [31:0] r;
    word_t       cin;
    if (op > ALU_CMP) return {1'b1, 32'h0};
    cin          = '0;
    cin[F_CARRY] = c;
    r = alu_fn(op, a, b, cin);
    if (op == ALU_CMP) r[15:0] = '0;
    return {1'b0, r};
  endfunction

  // ---------------- scoreboard ----------------
  logic [32:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- per-cycle strobe monitor ----------------
  logic strobe_seen = 1'b0;
  always @(negedge i_Clk) begin
    logic [5:0] s;
    s = {o_alu_latchA, o_alu_latchB, o_alu_latchF, o_alu_latchOp, o_alu_outputY, o_alu_outputF};
    check_eq("strobe_onehot", {31'b0, $countones(s) <= 1}, 32'd1);
    if (!(o_alu_latchA || o_alu_latchB || o_alu_latchF || o_alu_latchOp))
      check_eq("bus_idle_zero", o_alu_bus, 32'd0);
    if (o_req_ready || o_rsp_valid)
      check_eq("strobes_idle_done", s, 32'd0);
    if (s != 0) strobe_seen = 1'b1;
  end

  // ---------------- driver ----------------
  int         last_wait;
  word_t      last_y, last_flags;
  logic       last_err;
  logic       pend_valid = 1'b0;
  logic [3:0] pend_op;
  word_t      pend_a, pend_b;
  logic       pend_c;

  // Every call starts and ends at a falling edge.
  task automatic run_txn(input logic [3:0] op, input word_t a, input word_t b,
                         input logic c, input int hold);
    logic [32:0] exp;
    int n, lat;
    exp_q.push_back(ref_rsp(op, a, b, c));
    i_req_op = op; i_req_a = a; i_req_b = b; i_req_carry = c; i_req_valid = 1'b1;
    n = 0;
    while (!o_req_ready && n < 50) begin
      @(negedge i_Clk);
      n++;
    end
    last_wait = n;
    if (!o_req_ready) begin
      check_eq("accept_timeout", o_req_ready, 32'd1);
      i_req_valid = 1'b0;
      void'(exp_q.pop_front());
      return;
    end
    @(posedge i_Clk);
    #1;
    i_req_valid = 1'b0;
    strobe_seen = 1'b0;
    lat = 1;
    @(negedge i_Clk);
    while (!o_rsp_valid && lat < 40) begin
      @(negedge i_Clk);
      lat++;
    end
    exp = exp_q.pop_front();
    check_eq("rsp_valid", o_rsp_valid, 32'd1);
    check_eq("latency", lat, exp[32] ? 32'd1 : ALU_SEQ_LATENCY);
    check_eq("rsp_y", o_rsp_y, exp[15:0]);
    check_eq("rsp_flags", o_rsp_flags, exp[31:16]);
    check_eq("rsp_err", o_rsp_err, exp[32]);
    if (exp[32]) check_eq("rsvd_no_strobe", strobe_seen, 32'd0);
    last_y = o_rsp_y; last_flags = o_rsp_flags; last_err = o_rsp_err;
    if (!o_rsp_valid) return;
    for (int i = 0; i < hold; i++) begin
      if (pend_valid) begin
        i_req_op = pend_op; i_req_a = pend_a; i_req_b = pend_b;
        i_req_carry = pend_c; i_req_valid = 1'b1;
      end
      @(negedge i_Clk);
      check_eq("hold_valid", o_rsp_valid, 32'd1);
      check_eq("hold_y", o_rsp_y, exp[15:0]);
      check_eq("hold_flags", o_rsp_flags, exp[31:16]);
      check_eq("hold_req_ready", o_req_ready, 32'd0);
    end
    i_rsp_ready = 1'b1;
    @(posedge i_Clk);
    #1;
    i_rsp_ready = 1'b0;
    @(negedge i_Clk);
    check_eq("post_rsp_valid", o_rsp_valid, 32'd0);
    check_eq("post_req_ready", o_req_ready, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #1;
    check_eq("rst_req_ready", o_req_ready, 32'd1);
    check_eq("rst_rsp_valid", o_rsp_valid, 32'd0);
    check_eq("rst_rsp", {o_rsp_err, o_rsp_y}, 32'd0);
    check_eq("rst_bus", o_alu_bus, 32'd0);
    repeat (2) @(negedge i_Clk);
    i_Reset = 1'b0;
    @(negedge i_Clk);

    run_txn(ALU_ADD, 16'h0003, 16'h0004, 1'b0, 0);
    check_eq("add_y", last_y, 32'h7);
    check_eq("add_cz", {last_flags[F_ZERO], last_flags[F_CARRY]}, 32'd0);
    check_eq("add_err", last_err, 32'd0);

    run_txn(ALU_ADC, 16'hFFFF, 16'h0000, 1'b1, 0);
    check_eq("adc_y", last_y, 32'h0);
    check_eq("adc_cz", {last_flags[F_ZERO], last_flags[F_CARRY]}, 32'd3);

    run_txn(ALU_CMP, 16'h0005, 16'h0009, 1'b0, 1);
    check_eq("cmp_y", last_y, 32'h0);
    check_eq("cmp_leg", {last_flags[F_LESS], last_flags[F_EQUAL], last_flags[F_GREATER]}, 32'b100);

    run_txn(4'hF, 16'h1234, 16'h5678, 1'b1, 0);
    check_eq("rsvd_err", last_err, 32'd1);
    check_eq("rsvd_yf", {last_flags, last_y}, 32'd0);

    // Backpressure with a second request waiting behind the response.
    pend_valid = 1'b1;
    pend_op = ALU_XOR; pend_a = 16'hA5A5; pend_b = 16'h0FF0; pend_c = 1'b0;
    run_txn(ALU_ADD, 16'h1111, 16'h2222, 1'b1, 5);
    pend_valid = 1'b0;
    run_txn(pend_op, pend_a, pend_b, pend_c, 0);
    check_eq("pend_accept_at_idle", last_wait, 32'd0);

    // Reset asserted in the middle of EXEC.
    i_req_op = ALU_ADC; i_req_a = 16'h00FF; i_req_b = 16'h0001; i_req_carry = 1'b1;
    i_req_valid = 1'b1;
    @(posedge i_Clk);
    #1;
    i_req_valid = 1'b0;
    repeat (4) @(posedge i_Clk);
    #2;
    i_Reset = 1'b1;
    #1;
    check_eq("rstx_strobes", {o_alu_latchA, o_alu_latchB, o_alu_latchF, o_alu_latchOp,
                              o_alu_outputY, o_alu_outputF}, 32'd0);
    check_eq("rstx_rsp_valid", o_rsp_valid, 32'd0);
    check_eq("rstx_req_ready", o_req_ready, 32'd1);
    check_eq("rstx_bus", o_alu_bus, 32'd0);
    @(negedge i_Clk);
    i_Reset = 1'b0;
    @(negedge i_Clk);
    run_txn(ALU_SBC, 16'h0010, 16'h0001, 1'b0, 0);
    check_eq("sbc_y", last_y, 32'hF);
    check_eq("sbc_c", last_flags[F_CARRY], 32'd0);

    // Randomized operations, including reserved opcodes and backpressure.
    for (int k = 0; k < 40; k++) begin
      run_txn(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom),
              1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
